codon_scan_ctrl: RTL and testbench

Sequencer for the Genomatic codon-counting datapath. On a start request it loads the codon pattern table from the codon distributed ROM, then walks the gene ROM one nibble per cycle. It slides a window over the nibble stream and keeps a saturating match count per codon. It exposes the counts and a registered switch-selected count for the switch/LED front end.

---
 rtl/codon_scan_ctrl_pkg.sv | 21 ++
 rtl/codon_scan_ctrl_if.sv | 14 +
 rtl/codon_match_cnt.sv | 65 ++++++
 rtl/codon_scan_ctrl.sv | 113 +++++++++++
 tb/tb_codon_scan_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/codon_scan_ctrl_pkg.sv
// Shared configuration and types for the Genomatic codon-counting sequencer.
// Block sizing is set here; every codon_scan_ctrl file imports this package.
package geno_pkg;

  localparam int NUM_CODONS = 6;
  localparam int PAT_LEN    = 5;
  localparam int GENE_LEN   = 256;
  localparam int CNT_W      = 4;

  typedef logic [3:0]            nib_t;
  typedef nib_t [PAT_LEN-1:0]    pat_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } scan_state_t;

endpackage

// File: rtl/codon_scan_ctrl_if.sv
// ROM-side bus of the sequencer: codon table and gene ROM, both read
// combinationally (data is valid in the same cycle as the address).
interface codon_scan_ctrl_if;
  import geno_pkg::*;

  logic [4:0] cod_addr;
  nib_t       cod_data;
  logic [7:0] gen_addr;
  nib_t       gen_data;

  modport master (output cod_addr, output gen_addr, input cod_data, input gen_data);
  modport slave  (input cod_addr, input gen_addr, output cod_data, output gen_data);

endinterface

// File: rtl/codon_match_cnt.sv
// Codon pattern table, one comparator per codon against the next scan window,
// and a saturating match counter per codon.
module codon_match_cnt
  import geno_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [4:0]             load_idx_i,
  input  nib_t                   load_data_i,
  input  logic                   cmp_en_i,
  input  pat_t                   win_i,
  input  logic                   clear_i,
  output cnt_t [NUM_CODONS-1:0]  match_cnt_o
);

  pat_t [NUM_CODONS-1:0] pat_q;
  cnt_t [NUM_CODONS-1:0] cnt_q;
  logic [NUM_CODONS-1:0] hit;

  // NOTE: combinational blocks assign a default before any conditional logic,
  // so every path drives every output and no latch is inferred.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CODONS; i++) begin
      hit[i] = cmp_en_i && (win_i == pat_q[i]);
    end
  end

  // NOTE: the pattern table is a small flop array rather than a RAM, so it is
  // reset along with the rest of the state; a RAM-mapped table could not be.
  // Patterns are stored newest-nibble-first to line up with the window order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
    end else if (load_i) begin
      for (int i = 0; i < NUM_CODONS; i++) begin
        for (int k = 0; k < PAT_LEN; k++) begin
          if (load_idx_i == 5'(i * PAT_LEN + k)) begin
            pat_q[i][PAT_LEN-1-k] <= load_data_i;
          end
        end
      end
    end
  end

  // NOTE: clocked state uses non-blocking '<=' only, so every flop samples
  // values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CODONS; i++) begin
        if (hit[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign match_cnt_o = cnt_q;

endmodule

// File: rtl/codon_scan_ctrl.sv
// Run sequencer: loads the codon table, walks the gene ROM one nibble per
// cycle through a sliding window, and reports per-codon match counts.
module codon_scan_ctrl
  import geno_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  codon_scan_ctrl_if.master      rom,
  input  logic [2:0]             sel,
  output logic                   busy,
  output logic                   done,
  output cnt_t [NUM_CODONS-1:0]  match_cnt,
  output cnt_t                   sel_cnt
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [4:0]        COD_LAST  = 5'(NUM_CODONS * PAT_LEN - 1);
  localparam logic [7:0]        GEN_LAST  = 8'(GENE_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_CMP  = FILL_W'(PAT_LEN - 1);

  scan_state_t       state_q, state_d;
  logic [4:0]        cod_addr_q, cod_addr_d;
  logic [7:0]        gen_addr_q, gen_addr_d;
  pat_t              win_q, win_d, nxt_win;
  logic [FILL_W-1:0] fill_q, fill_d;
  cnt_t              sel_cnt_q, sel_cnt_d;
  logic              accept, cmp_en;

  always_comb begin
    state_d    = state_q;
    cod_addr_d = cod_addr_q;
    gen_addr_d = gen_addr_q;
    win_d      = win_q;
    fill_d     = fill_q;
    cmp_en     = 1'b0;
    accept     = start && ((state_q == IDLE) || (state_q == DONE));
    nxt_win    = {win_q[PAT_LEN-2:0], rom.gen_data};

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d    = LOAD;
          cod_addr_d = '0;
          win_d      = '0;
          fill_d     = '0;
        end
      end
      LOAD: begin
        if (cod_addr_q == COD_LAST) begin
          state_d    = SCAN;
          gen_addr_d = '0;
        end else begin
          cod_addr_d = cod_addr_q + 5'd1;
        end
      end
      SCAN: begin
        win_d  = nxt_win;
        cmp_en = (fill_q >= FILL_CMP);
        if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
        // The last address gets its compare this cycle; the address then holds.
        if (gen_addr_q == GEN_LAST) state_d = DONE;
        else                        gen_addr_d = gen_addr_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_cnt_d = '0;
    for (int i = 0; i < NUM_CODONS; i++) begin
      if (sel == 3'(i)) sel_cnt_d = match_cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cod_addr_q <= '0;
      gen_addr_q <= '0;
      win_q      <= '0;
      fill_q     <= '0;
      sel_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cod_addr_q <= cod_addr_d;
      gen_addr_q <= gen_addr_d;
      win_q      <= win_d;
      fill_q     <= fill_d;
      sel_cnt_q  <= sel_cnt_d;
    end
  end

  codon_match_cnt u_match (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (state_q == LOAD),
    .load_idx_i  (cod_addr_q),
    .load_data_i (rom.cod_data),
    .cmp_en_i    (cmp_en),
    .win_i       (nxt_win),
    .clear_i     (accept),
    .match_cnt_o (match_cnt)
  );

  assign rom.cod_addr = cod_addr_q;
  assign rom.gen_addr = gen_addr_q;
  assign busy         = (state_q == LOAD) || (state_q == SCAN);
  assign done         = (state_q == DONE);
  assign sel_cnt      = sel_cnt_q;

endmodule

// File: tb/tb_codon_scan_ctrl.sv
// Bench for codon_scan_ctrl: ROM models, directed scenarios, a sel_cnt
// vector table and randomized runs checked against a pattern-search model.
module tb_codon_scan_ctrl;
  import geno_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [2:0]            sel;
  logic                  busy, done;
  cnt_t [NUM_CODONS-1:0] match_cnt;
  cnt_t                  sel_cnt;

  codon_scan_ctrl_if rif ();

  logic [3:0] cod_rom [32];
  logic [3:0] gen_rom [GENE_LEN];

  assign rif.cod_data = cod_rom[rif.cod_addr];
  assign rif.gen_data = gen_rom[rif.gen_addr];

  always #5 clk = ~clk;

  codon_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rom       (rif),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt),
    .sel_cnt   (sel_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] exp;
  } sel_vec_t;

  sel_vec_t svec [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: count every (overlapping) occurrence of codon c in the gene,
  // saturating at the counter maximum; no wrap past the end of the gene.
  function automatic int model_cnt(input int c);
    int n = 0;
    for (int p = 0; p + PAT_LEN <= GENE_LEN; p++) begin
      bit ok = 1'b1;
      for (int k = 0; k < PAT_LEN; k++)
        if (gen_rom[p + k] != cod_rom[c * PAT_LEN + k]) ok = 1'b0;
      if (ok && n < (2 ** CNT_W - 1)) n++;
    end
    return n;
  endfunction

  task automatic set_pat(input int c, input logic [19:0] nibs);
    for (int k = 0; k < PAT_LEN; k++) cod_rom[c * PAT_LEN + k] = nibs[19 - 4 * k -: 4];
  endtask

  task automatic all_pats(input logic [19:0] nibs);
    for (int c = 0; c < NUM_CODONS; c++) set_pat(c, nibs);
  endtask

  task automatic fill_gene(input logic [3:0] v);
    for (int a = 0; a < GENE_LEN; a++) gen_rom[a] = v;
  endtask

  task automatic put_seq(input int addr, input logic [19:0] nibs);
    for (int k = 0; k < PAT_LEN; k++) gen_rom[(addr + k) % GENE_LEN] = nibs[19 - 4 * k -: 4];
  endtask

  task automatic basic_setup();
    all_pats(20'hFFFFF);
    set_pat(0, 20'h12345);
    fill_gene(4'h0);
    put_seq(10, 20'h12345);
    put_seq(100, 20'h12345);
  endtask

  task automatic run(input string tag, input bit disturb);
    int n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      start = disturb && (n == 10 || n == 130);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " busy_cycles"}, n, 286);
    check({tag, " done"}, done, 1);
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < NUM_CODONS; i++)
      check($sformatf("%s cnt%0d", tag, i), match_cnt[i], model_cnt(i));
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; sel = 3'd0;
    all_pats(20'h00000);
    fill_gene(4'h0);
    svec[0] = '{3'd0, 4'd2}; svec[1] = '{3'd1, 4'd0};
    svec[2] = '{3'd2, 4'd0}; svec[3] = '{3'd3, 4'd0};
    svec[4] = '{3'd4, 4'd0}; svec[5] = '{3'd5, 4'd0};
    svec[6] = '{3'd6, 4'd0}; svec[7] = '{3'd7, 4'd0};

    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst cod_addr", rif.cod_addr, 0);
    check("rst gen_addr", rif.gen_addr, 0);
    check("rst sel_cnt", sel_cnt, 0);
    check("rst match_cnt", match_cnt, 0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle busy", busy, 0);
    check("idle done", done, 0);

    // Basic count, then sel_cnt vector table in DONE.
    basic_setup();
    run("basic", 1'b0);
    check_model("basic");
    check("basic cnt0", match_cnt[0], 2);
    check("basic gen_addr hold", rif.gen_addr, 255);
    for (int i = 0; i < 8; i++) begin
      sel = svec[i].sel;
      @(negedge clk);
      check($sformatf("sel_cnt sel=%0d", svec[i].sel), sel_cnt, svec[i].exp);
    end
    sel = 3'd0;
    @(posedge clk); #1;
    check("sel_cnt latency", sel_cnt, 2);
    @(negedge clk); sel = 3'd1;
    #1 check("sel_cnt registered", sel_cnt, 2);
    @(posedge clk); #1;
    check("sel_cnt updated", sel_cnt, 0);

    // Overlapping occurrences.
    all_pats(20'hFFFFF);
    set_pat(2, 20'h33333);
    fill_gene(4'h0);
    for (int a = 40; a <= 46; a++) gen_rom[a] = 4'h3;
    run("overlap", 1'b0);
    check_model("overlap");
    check("overlap cnt2", match_cnt[2], 3);

    // Saturation with two identical codons matching together.
    all_pats(20'hFFFFF);
    set_pat(1, 20'h77777);
    set_pat(4, 20'h77777);
    fill_gene(4'h7);
    run("sat", 1'b0);
    check("sat cnt1", match_cnt[1], 15);
    check("sat cnt4", match_cnt[4], 15);
    check_model("sat");

    // Occurrence ending on the last gene address.
    all_pats(20'hFFFFF);
    set_pat(5, 20'h9ABCD);
    fill_gene(4'h0);
    put_seq(251, 20'h9ABCD);
    run("edge", 1'b0);
    check("edge cnt5", match_cnt[5], 1);
    check("edge gen_addr", rif.gen_addr, 255);
    check_model("edge");

    // Occurrence only present through address wrap; started from DONE,
    // so the earlier count must also clear. Repeated to cover window carry.
    set_pat(3, 20'h12345);
    fill_gene(4'h0);
    put_seq(254, 20'h12345);
    run("wrap", 1'b0);
    check("wrap cnt3", match_cnt[3], 0);
    check("wrap cnt5 cleared", match_cnt[5], 0);
    run("wrap2", 1'b0);
    check("wrap2 cnt3", match_cnt[3], 0);

    // start pulses while busy must be ignored.
    basic_setup();
    run("disturb", 1'b1);
    check_model("disturb");
    check("disturb cnt0", match_cnt[0], 2);

    // Asynchronous reset in the middle of SCAN.
    sel = 3'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (busy && n < 80) begin
      n++;
      @(negedge clk);
    end
    check("midrst reached scan", n, 80);
    check("midrst partial cnt0", match_cnt[0], 1);
    #2 rst = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst cod_addr", rif.cod_addr, 0);
    check("midrst gen_addr", rif.gen_addr, 0);
    check("midrst match_cnt", match_cnt, 0);
    check("midrst sel_cnt", sel_cnt, 0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst idle busy", busy, 0);
    check("midrst idle done", done, 0);
    run("after_rst", 1'b0);
    check_model("after_rst");

    // Randomized tables over a two-letter alphabet so matches are frequent.
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < NUM_CODONS * PAT_LEN; a++) cod_rom[a] = 4'($urandom_range(0, 1));
      for (int a = 0; a < GENE_LEN; a++) gen_rom[a] = 4'($urandom_range(0, 1));
      run($sformatf("rand%0d", it), 1'b0);
      check_model($sformatf("rand%0d", it));
      sel = 3'($urandom_range(0, 7));
      @(negedge clk);
      check($sformatf("rand%0d sel_cnt", it), sel_cnt, (sel < NUM_CODONS) ? model_cnt(int'(sel)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
